// File: rtl/i281_pkg.sv
// Shared i281 encodings: opcodes, INPUT/SHIFT/BRANCH subtypes, sequencer states, flag bit positions.
// Used by the fetch sequencer and the standalone opcode decoder.
package i281_pkg;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_INPUT  = 4'h1;
  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [3:0] OP_LOADI  = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SUBI   = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_LOADF  = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_STOREF = 4'hB;
  localparam logic [3:0] OP_SHIFT  = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;

  localparam logic [1:0] IN_C  = 2'b00;
  localparam logic [1:0] IN_CF = 2'b01;
  localparam logic [1:0] IN_D  = 2'b10;
  localparam logic [1:0] IN_DF = 2'b11;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_GT = 2'b10;
  localparam logic [1:0] BR_GE = 2'b11;

  typedef enum logic [1:0] {
    SEQ_HALTED = 2'd0,
    SEQ_FETCH  = 2'd1,
    SEQ_EXEC   = 2'd2
  } seq_state_t;

  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_NEGATIVE = 1;
  localparam int FLAG_ZERO     = 0;

endpackage

// File: rtl/i281_opcode_decoder.sv
// Instruction word to 23 one-hot instruction lines; purely combinational, zero latency.
// No flow control: output follows the input word continuously.
module i281_opcode_decoder
  import i281_pkg::*;
(
  input  logic [15:0] instr,
  output logic        noop,
  output logic        input_datac,
  output logic        input_datacf,
  output logic        input_datad,
  output logic        input_datadf,
  output logic        move,
  output logic        loadi_loadp,
  output logic        add,
  output logic        addi,
  output logic        sub,
  output logic        subi,
  output logic        load,
  output logic        loadf,
  output logic        store,
  output logic        storef,
  output logic        shiftl,
  output logic        shiftr,
  output logic        cmp,
  output logic        jump,
  output logic        bre_brz,
  output logic        brne_brnz,
  output logic        brg,
  output logic        brge
);

  logic [3:0] opcode;
  logic [1:0] y;
  logic       unused_fields;

  assign opcode = instr[15:12];
  assign y      = instr[9:8];
  // X and IMM carry operands only; they never select an instruction line.
  assign unused_fields = ^{instr[11:10], instr[7:0]};

  always_comb begin
    noop = 1'b0; input_datac = 1'b0; input_datacf = 1'b0; input_datad = 1'b0;
    input_datadf = 1'b0; move = 1'b0; loadi_loadp = 1'b0; add = 1'b0; addi = 1'b0;
    sub = 1'b0; subi = 1'b0; load = 1'b0; loadf = 1'b0; store = 1'b0; storef = 1'b0;
    shiftl = 1'b0; shiftr = 1'b0; cmp = 1'b0; jump = 1'b0; bre_brz = 1'b0;
    brne_brnz = 1'b0; brg = 1'b0; brge = 1'b0;
    case (opcode)
      OP_NOOP:   noop = 1'b1;
      OP_INPUT: begin
        case (y)
          IN_C:    input_datac  = 1'b1;
          IN_CF:   input_datacf = 1'b1;
          IN_D:    input_datad  = 1'b1;
          default: input_datadf = 1'b1;
        endcase
      end
      OP_MOVE:   move        = 1'b1;
      OP_LOADI:  loadi_loadp = 1'b1;
      OP_ADD:    add         = 1'b1;
      OP_ADDI:   addi        = 1'b1;
      OP_SUB:    sub         = 1'b1;
      OP_SUBI:   subi        = 1'b1;
      OP_LOAD:   load        = 1'b1;
      OP_LOADF:  loadf       = 1'b1;
      OP_STORE:  store       = 1'b1;
      OP_STOREF: storef      = 1'b1;
      OP_SHIFT: begin
        if (y[0] == SHIFT_RIGHT) shiftr = 1'b1;
        else                     shiftl = 1'b1;
      end
      OP_CMP:    cmp         = 1'b1;
      OP_JUMP:   jump        = 1'b1;
      OP_BRANCH: begin
        case (y)
          BR_EQ:   bre_brz   = 1'b1;
          BR_NE:   brne_brnz = 1'b1;
          BR_GT:   brg       = 1'b1;
          default: brge      = 1'b1;
        endcase
      end
      default:   noop        = 1'b1;
    endcase
  end

endmodule

// File: rtl/i281_fetch_sequencer.sv
// PC/IR/flags owner with HALTED/FETCH/EXEC sequencing; two cycles per instruction, PC and flags update at end of EXEC.
// No backpressure: free run or single step; step edges seen outside HALTED are dropped.
module i281_fetch_sequencer
  import i281_pkg::*;
#(
  parameter int PC_WIDTH = 6
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                RUN_MODE,
  input  logic                STEP_REQ,
  output logic [PC_WIDTH-1:0] IMEM_ADDR,
  input  logic [15:0]         IMEM_RDATA,
  input  logic                PC_MUX,
  input  logic                FLAGS_WRITE_ENABLE,
  input  logic [3:0]          ALU_FLAGS,
  output logic [PC_WIDTH-1:0] PC,
  output logic [15:0]         INSTR,
  output logic [1:0]          X,
  output logic [1:0]          Y,
  output logic [7:0]          IMM,
  output logic                EXEC_VALID,
  output logic                NOOP,
  output logic                INPUT_DATAC,
  output logic                INPUT_DATACF,
  output logic                INPUT_DATAD,
  output logic                INPUT_DATADF,
  output logic                MOVE,
  output logic                LOADI_LOADP,
  output logic                ADD,
  output logic                ADDI,
  output logic                SUB,
  output logic                SUBI,
  output logic                LOAD,
  output logic                LOADF,
  output logic                STORE,
  output logic                STOREF,
  output logic                SHIFTL,
  output logic                SHIFTR,
  output logic                CMP,
  output logic                JUMP,
  output logic                BRE_BRZ,
  output logic                BRNE_BRNZ,
  output logic                BRG,
  output logic                BRGE,
  output logic                CARRY_FLAG,
  output logic                OVERFLOW_FLAG,
  output logic                NEGATIVE_FLAG,
  output logic                ZERO_FLAG,
  output logic [1:0]          SEQ_STATE
);

  seq_state_t          state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [15:0]         instr_q;
  logic [3:0]          flags_q;
  logic                step_q;
  logic                step_edge;
  logic                exec_valid_q;

  assign step_edge = STEP_REQ & ~step_q;
  assign pc_inc    = pc_q + PC_WIDTH'(1);
  // Adding the low IMM bits is the same as a sign-extended add truncated to PC_WIDTH.
  assign pc_next   = PC_MUX ? pc_inc + instr_q[PC_WIDTH-1:0] : pc_inc;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= SEQ_HALTED;
      exec_valid_q <= 1'b0;
      pc_q         <= '0;
      instr_q      <= 16'h0000;
      flags_q      <= 4'b0000;
      step_q       <= 1'b0;
    end else begin
      step_q <= STEP_REQ;
      case (state)
        SEQ_HALTED: begin
          if (RUN_MODE || step_edge) state <= SEQ_FETCH;
        end
        SEQ_FETCH: begin
          instr_q      <= IMEM_RDATA;
          state        <= SEQ_EXEC;
          exec_valid_q <= 1'b1;
        end
        SEQ_EXEC: begin
          pc_q         <= pc_next;
          if (FLAGS_WRITE_ENABLE) flags_q <= ALU_FLAGS;
          exec_valid_q <= 1'b0;
          state        <= RUN_MODE ? SEQ_FETCH : SEQ_HALTED;
        end
        default: begin
          state        <= SEQ_HALTED;
          exec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC            = pc_q;
  assign IMEM_ADDR     = pc_q;
  assign INSTR         = instr_q;
  assign X             = instr_q[11:10];
  assign Y             = instr_q[9:8];
  assign IMM           = instr_q[7:0];
  assign EXEC_VALID    = exec_valid_q;
  assign SEQ_STATE     = state;
  assign CARRY_FLAG    = flags_q[FLAG_CARRY];
  assign OVERFLOW_FLAG = flags_q[FLAG_OVERFLOW];
  assign NEGATIVE_FLAG = flags_q[FLAG_NEGATIVE];
  assign ZERO_FLAG     = flags_q[FLAG_ZERO];

  i281_opcode_decoder u_decoder (
    .instr        (instr_q),
    .noop         (NOOP),
    .input_datac  (INPUT_DATAC),
    .input_datacf (INPUT_DATACF),
    .input_datad  (INPUT_DATAD),
    .input_datadf (INPUT_DATADF),
    .move         (MOVE),
    .loadi_loadp  (LOADI_LOADP),
    .add          (ADD),
    .addi         (ADDI),
    .sub          (SUB),
    .subi         (SUBI),
    .load         (LOAD),
    .loadf        (LOADF),
    .store        (STORE),
    .storef       (STOREF),
    .shiftl       (SHIFTL),
    .shiftr       (SHIFTR),
    .cmp          (CMP),
    .jump         (JUMP),
    .bre_brz      (BRE_BRZ),
    .brne_brnz    (BRNE_BRNZ),
    .brg          (BRG),
    .brge         (BRGE)
  );

endmodule

// File: tb/tb_i281_fetch_sequencer.sv
// Directed bench for i281_fetch_sequencer: reset, free run, branch/jump/wrap, single step, flags, decode table.
module tb_i281_fetch_sequencer;

  localparam int PW = 6;

  logic          CLOCK = 1'b0;
  logic          RESET, RUN_MODE, STEP_REQ, PC_MUX, FLAGS_WRITE_ENABLE;
  logic [3:0]    ALU_FLAGS;
  logic [PW-1:0] IMEM_ADDR, PC;
  logic [15:0]   IMEM_RDATA, INSTR;
  logic [1:0]    X, Y, SEQ_STATE;
  logic [7:0]    IMM;
  logic          EXEC_VALID;
  logic NOOP, INPUT_DATAC, INPUT_DATACF, INPUT_DATAD, INPUT_DATADF, MOVE, LOADI_LOADP;
  logic ADD, ADDI, SUB, SUBI, LOAD, LOADF, STORE, STOREF, SHIFTL, SHIFTR, CMP, JUMP;
  logic BRE_BRZ, BRNE_BRNZ, BRG, BRGE;
  logic CARRY_FLAG, OVERFLOW_FLAG, NEGATIVE_FLAG, ZERO_FLAG;

  logic [15:0] imem [64];
  logic [22:0] dec;
  logic [3:0]  flags;

  int vectors = 0;
  int miscompares = 0;

  assign IMEM_RDATA = imem[IMEM_ADDR];
  assign dec = {NOOP, INPUT_DATAC, INPUT_DATACF, INPUT_DATAD, INPUT_DATADF, MOVE, LOADI_LOADP,
                ADD, ADDI, SUB, SUBI, LOAD, LOADF, STORE, STOREF, SHIFTL, SHIFTR, CMP, JUMP,
                BRE_BRZ, BRNE_BRNZ, BRG, BRGE};
  assign flags = {CARRY_FLAG, OVERFLOW_FLAG, NEGATIVE_FLAG, ZERO_FLAG};

  always #5 CLOCK = ~CLOCK;

  i281_fetch_sequencer #(.PC_WIDTH(PW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RUN_MODE(RUN_MODE), .STEP_REQ(STEP_REQ),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA), .PC_MUX(PC_MUX),
    .FLAGS_WRITE_ENABLE(FLAGS_WRITE_ENABLE), .ALU_FLAGS(ALU_FLAGS),
    .PC(PC), .INSTR(INSTR), .X(X), .Y(Y), .IMM(IMM), .EXEC_VALID(EXEC_VALID),
    .NOOP(NOOP), .INPUT_DATAC(INPUT_DATAC), .INPUT_DATACF(INPUT_DATACF),
    .INPUT_DATAD(INPUT_DATAD), .INPUT_DATADF(INPUT_DATADF), .MOVE(MOVE),
    .LOADI_LOADP(LOADI_LOADP), .ADD(ADD), .ADDI(ADDI), .SUB(SUB), .SUBI(SUBI),
    .LOAD(LOAD), .LOADF(LOADF), .STORE(STORE), .STOREF(STOREF), .SHIFTL(SHIFTL),
    .SHIFTR(SHIFTR), .CMP(CMP), .JUMP(JUMP), .BRE_BRZ(BRE_BRZ), .BRNE_BRNZ(BRNE_BRNZ),
    .BRG(BRG), .BRGE(BRGE), .CARRY_FLAG(CARRY_FLAG), .OVERFLOW_FLAG(OVERFLOW_FLAG),
    .NEGATIVE_FLAG(NEGATIVE_FLAG), .ZERO_FLAG(ZERO_FLAG), .SEQ_STATE(SEQ_STATE)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; RUN_MODE = 1'b0; STEP_REQ = 1'b0; PC_MUX = 1'b0;
    FLAGS_WRITE_ENABLE = 1'b0; ALU_FLAGS = 4'b0000;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Leaves the sequencer in EXEC of the stepped instruction.
  task automatic step_to_exec();
    STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    tick();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      step_to_exec();
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (PC !== 6'd0) begin miscompares++; $display("FAIL reset_pc: got %0d expected 0", PC); end
    vectors++; if (INSTR !== 16'h0000) begin miscompares++; $display("FAIL reset_instr: got %h expected 0000", INSTR); end
    vectors++; if (dec !== 23'h400000) begin miscompares++; $display("FAIL reset_decode: got %h expected 400000", dec); end
    vectors++; if (SEQ_STATE !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", SEQ_STATE); end
    vectors++; if (EXEC_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_exec_valid: got %b expected 0", EXEC_VALID); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", flags); end
  endtask

  task automatic test_run_add();
    do_reset();
    imem[0] = 16'h4100;
    RUN_MODE = 1'b1;
    tick();
    vectors++; if (SEQ_STATE !== 2'd1 || EXEC_VALID !== 1'b0) begin miscompares++; $display("FAIL run_fetch: got state %0d ev %b expected 1 0", SEQ_STATE, EXEC_VALID); end
    tick();
    vectors++; if (EXEC_VALID !== 1'b1 || SEQ_STATE !== 2'd2) begin miscompares++; $display("FAIL run_exec: got ev %b state %0d expected 1 2", EXEC_VALID, SEQ_STATE); end
    vectors++; if (dec !== 23'h008000) begin miscompares++; $display("FAIL run_add_decode: got %h expected 008000", dec); end
    vectors++; if (X !== 2'd0 || Y !== 2'd1 || IMM !== 8'h00) begin miscompares++; $display("FAIL run_add_fields: got x %0d y %0d imm %h expected 0 1 00", X, Y, IMM); end
    tick();
    vectors++; if (PC !== 6'd1 || IMEM_ADDR !== 6'd1 || SEQ_STATE !== 2'd1) begin miscompares++; $display("FAIL run_next_fetch: got pc %0d addr %0d state %0d expected 1 1 1", PC, IMEM_ADDR, SEQ_STATE); end
    RUN_MODE = 1'b0;
    tick();
    tick();
    vectors++; if (PC !== 6'd2 || SEQ_STATE !== 2'd0) begin miscompares++; $display("FAIL run_stop: got pc %0d state %0d expected 2 0", PC, SEQ_STATE); end
  endtask

  task automatic test_branch();
    do_reset();
    imem[5] = 16'hF0FD;
    step_n(5);
    vectors++; if (PC !== 6'd5) begin miscompares++; $display("FAIL branch_setup_pc: got %0d expected 5", PC); end
    PC_MUX = 1'b1;
    step_to_exec();
    vectors++; if (dec !== 23'h000008) begin miscompares++; $display("FAIL branch_decode: got %h expected 000008", dec); end
    tick();
    vectors++; if (PC !== 6'd3) begin miscompares++; $display("FAIL branch_taken_pc: got %0d expected 3", PC); end
    do_reset();
    imem[5] = 16'hF0FD;
    step_n(5);
    step_n(1);
    vectors++; if (PC !== 6'd6) begin miscompares++; $display("FAIL branch_not_taken_pc: got %0d expected 6", PC); end
  endtask

  task automatic test_wrap_jump();
    do_reset();
    step_n(63);
    vectors++; if (PC !== 6'd63) begin miscompares++; $display("FAIL wrap_setup_pc: got %0d expected 63", PC); end
    step_n(1);
    vectors++; if (PC !== 6'd0) begin miscompares++; $display("FAIL wrap_pc: got %0d expected 0", PC); end
    imem[0] = 16'hE07F;
    PC_MUX = 1'b1;
    step_to_exec();
    vectors++; if (dec !== 23'h000010 || IMM !== 8'h7F) begin miscompares++; $display("FAIL jump_decode: got %h imm %h expected 000010 7f", dec, IMM); end
    tick();
    vectors++; if (PC !== 6'd0 || SEQ_STATE !== 2'd0) begin miscompares++; $display("FAIL jump_7f_pc: got pc %0d state %0d expected 0 0", PC, SEQ_STATE); end
    imem[0] = 16'hE005;
    step_n(1);
    vectors++; if (PC !== 6'd6) begin miscompares++; $display("FAIL jump_05_pc: got %0d expected 6", PC); end
  endtask

  task automatic test_step_hold();
    int execs;
    do_reset();
    execs = 0;
    STEP_REQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (EXEC_VALID === 1'b1) execs++;
    end
    STEP_REQ = 1'b0;
    tick();
    tick();
    vectors++; if (execs !== 1) begin miscompares++; $display("FAIL step_hold_execs: got %0d expected 1", execs); end
    vectors++; if (SEQ_STATE !== 2'd0 || PC !== 6'd1) begin miscompares++; $display("FAIL step_hold_end: got state %0d pc %0d expected 0 1", SEQ_STATE, PC); end
  endtask

  task automatic test_step_discard();
    do_reset();
    STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    tick();
    STEP_REQ = 1'b1;
    tick();
    tick();
    tick();
    vectors++; if (SEQ_STATE !== 2'd0 || PC !== 6'd1) begin miscompares++; $display("FAIL step_discard: got state %0d pc %0d expected 0 1", SEQ_STATE, PC); end
    STEP_REQ = 1'b0;
    tick();
  endtask

  task automatic test_flags();
    do_reset();
    imem[0] = 16'hD000;
    FLAGS_WRITE_ENABLE = 1'b1;
    ALU_FLAGS = 4'b1001;
    tick();
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL flags_halted: got %b expected 0000", flags); end
    STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL flags_fetch: got %b expected 0000", flags); end
    tick();
    vectors++; if (flags !== 4'b0000 || CMP !== 1'b1) begin miscompares++; $display("FAIL flags_exec: got %b cmp %b expected 0000 1", flags, CMP); end
    tick();
    vectors++; if (CARRY_FLAG !== 1'b1 || ZERO_FLAG !== 1'b1 || flags !== 4'b1001) begin miscompares++; $display("FAIL flags_written: got %b expected 1001", flags); end
    FLAGS_WRITE_ENABLE = 1'b0;
    ALU_FLAGS = 4'b0110;
    step_n(1);
    vectors++; if (flags !== 4'b1001) begin miscompares++; $display("FAIL flags_hold: got %b expected 1001", flags); end
    FLAGS_WRITE_ENABLE = 1'b1;
    step_n(1);
    vectors++; if (flags !== 4'b0110) begin miscompares++; $display("FAIL flags_rewrite: got %b expected 0110", flags); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    imem[1] = 16'hE005;
    step_n(1);
    PC_MUX = 1'b1;
    FLAGS_WRITE_ENABLE = 1'b1;
    ALU_FLAGS = 4'b1111;
    step_to_exec();
    vectors++; if (SEQ_STATE !== 2'd2 || INSTR !== 16'hE005) begin miscompares++; $display("FAIL abort_setup: got state %0d instr %h expected 2 e005", SEQ_STATE, INSTR); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    vectors++; if (PC !== 6'd0 || INSTR !== 16'h0000) begin miscompares++; $display("FAIL abort_pc_instr: got pc %0d instr %h expected 0 0000", PC, INSTR); end
    vectors++; if (SEQ_STATE !== 2'd0 || EXEC_VALID !== 1'b0 || flags !== 4'b0000) begin miscompares++; $display("FAIL abort_state: got state %0d ev %b flags %b expected 0 0 0000", SEQ_STATE, EXEC_VALID, flags); end
  endtask

  task automatic test_decode_table();
    logic [15:0] words [23];
    words = '{16'h0000, 16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h2ABC, 16'h3000,
              16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000, 16'h9000, 16'hA000,
              16'hB000, 16'hC200, 16'hC300, 16'hD000, 16'hE000, 16'hF000, 16'hF100,
              16'hF200, 16'hF300};
    do_reset();
    for (int i = 0; i < 23; i++) imem[i] = words[i];
    for (int i = 0; i < 23; i++) begin
      logic [22:0] expv;
      expv = 23'd1 << (22 - i);
      step_to_exec();
      vectors++; if (dec !== expv) begin miscompares++; $display("FAIL decode_%0d: word %h got %h expected %h", i, words[i], dec, expv); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_run_add();
    test_branch();
    test_wrap_jump();
    test_step_hold();
    test_step_discard();
    test_flags();
    test_reset_mid_exec();
    test_decode_table();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
